pipe_skid_stage: RTL and testbench
==================================

// Module: pipe_skid_stage
// PURPOSE
//  Generic inter-stage pipeline register: carries one bundle of stage payload (control + data).
//  Replaces hand-written per-stage registers driven by a global stall vector with a valid/ready
//  handshake and a 2-entry skid buffer, giving full throughput and a registered in_ready.
//  Sits between any two CPU pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
//  Adds a synchronous flush that injects a bubble.
// PARAMETERS
//  DATA_W   128  payload width in bits, >=1 (control bits and operands packed by the instantiating stage)
//  CNT_W    16   width of stall counter (used only with PIPE_STAGE_STALL_CNT_EN)
// PORTS
//  clk        in   1       clock, rising edge
//  reset      in   1       asynchronous, active-low reset
//  flush      in   1       synchronous kill of all held entries (branch/exception)
//  in_valid   in   1       upstream has a payload
//  in_ready   out  1       stage can accept; registered, no combinational path from out_ready
//  in_data    in   DATA_W  upstream payload
//  out_valid  out  1       out_data holds a live payload
//  out_ready  in   1       downstream accepts this cycle
//  out_data   out  DATA_W  payload to downstream; zero whenever out_valid=0
//  stall_cnt  out  CNT_W   only with PIPE_STAGE_STALL_CNT_EN
// BEHAVIOUR
//  Storage: main reg (drives out_*) + skid reg; valid bits main_v, skid_v.
//  Reset (reset=0, async): main_v=skid_v=0, both data regs=0, out_valid=0, out_data=0,
//   in_ready=1, stall_cnt=0. Release is synchronous to clk.
//  acc = in_valid & in_ready; rel = out_valid & out_ready.
//  States: EMPTY (main_v=0,skid_v=0), ONE (1,0), FULL (1,1). in_ready = ~skid_v (registered).
//   EMPTY: acc -> ONE, main<=in_data. else stay.
//   ONE: acc&rel -> ONE, main<=in_data. acc&~rel -> FULL, skid<=in_data.
//        ~acc&rel -> EMPTY, main data<=0. neither -> stay, hold.
//   FULL: in_ready=0 so acc impossible. rel -> ONE, main<=skid, skid<=0. else hold.
//  Latency: 1 cycle in_data -> out_data with out_ready=1. Throughput 1 payload/cycle.
//  Order strictly FIFO; no payload is duplicated or dropped except by flush.
//  flush=1: next cycle EMPTY, all data regs 0, in_ready=1. Overrides acc and rel.
//   The in_data offered that cycle is discarded. A rel in the same cycle still counts downstream.
//  Bubble: out_valid=0 always with out_data=0, so a stray consumer sees a NOP.
//  in_valid may drop without acceptance; no upstream hold rule is enforced (cf. AXI).
//  X on in_data while in_valid=0 must never propagate into the regs.
// CONFIGURATION
//  PIPE_STAGE_STALL_CNT_EN defined:
//   stall_cnt port exists. It increments by 1 every cycle with out_valid=1 & out_ready=0,
//   saturates at 2^CNT_W-1, is unaffected by flush, and is cleared only by reset.
//  PIPE_STAGE_STALL_CNT_EN undefined:
//   no stall_cnt port and no counter logic. All other behaviour is identical.
// TESTING (DATA_W=32)
//  1 Reset: assert reset=0 mid-stream in state FULL -> same cycle out_valid=0, out_data=0,
//    in_ready=1. After release, EMPTY.
//  2 Streaming: out_ready=1, in_valid=1, in_data=1,2,3..100 one per cycle -> out_data 1..100
//    on consecutive cycles, 1 cycle later. in_ready stays 1.
//  3 Skid: in_data=0xA then 0xB while out_ready=0 -> FULL, in_ready=0.
//    Raise out_ready -> 0xA then 0xB out on consecutive cycles; in_ready=1 the cycle after 0xA leaves.
//  4 Flush: in FULL (0xA,0xB), flush=1 with in_valid=1, in_data=0xC
//    -> next cycle out_valid=0, out_data=0, in_ready=1. 0xC is never emitted.
//  5 Random valid/ready (10k cycles, scoreboard) -> output sequence equals accepted input sequence.
//    out_data=0 whenever out_valid=0. in_ready never depends combinationally on out_ready.
//  6 With PIPE_STAGE_STALL_CNT_EN and CNT_W=4: hold out_valid=1, out_ready=0 for 20 cycles
//    -> stall_cnt=15 (saturated). flush leaves it at 15. reset clears it to 0.

Source files
------------

// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: generic inter-stage pipeline register with a valid/ready
// handshake and a 2-entry skid buffer (main + skid). in_ready is decoded from
// the state register only, so it has no combinational path from out_ready.
// A synchronous flush empties the stage and injects a bubble (out_data = 0).
// Optional feature macro: PIPE_STAGE_STALL_CNT_EN adds a saturating stall
// counter port (stall_cnt) that counts cycles with out_valid=1 & out_ready=0.
module pipe_skid_stage #(
  parameter int DATA_W = 128
`ifdef PIPE_STAGE_STALL_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_STALL_CNT_EN
  , output logic [CNT_W-1:0] stall_cnt
`endif
);

  // Occupancy: EMPTY (nothing held), ONE (main only), FULL (main + skid).
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_q,  main_d;
  logic [DATA_W-1:0] skid_q,  skid_d;
  logic              acc, rel;

  // Handshake outputs come straight from registered state and the main register.
  // main_q is kept at zero whenever the stage is empty, so a bubble reads as 0.
  assign out_valid = (state_q != EMPTY);
  assign in_ready  = (state_q != FULL);
  assign out_data  = main_q;

  assign acc = in_valid & in_ready;
  assign rel = out_valid & out_ready;

  // State and payload registers.
  // NOTE: the payload registers are reset too, because an empty stage must
  // present out_data = 0 immediately, even before the first clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments so that every
      // register samples the pre-edge values, independent of statement order.
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Next-state and next-payload logic; flush overrides accept and release.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    if (flush) begin
      state_d = EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (acc) begin
            state_d = ONE;
            main_d  = in_data;
          end
        end
        ONE: begin
          if (acc && rel) begin
            main_d = in_data;
          end else if (acc) begin
            state_d = FULL;
            skid_d  = in_data;
          end else if (rel) begin
            state_d = EMPTY;
            main_d  = '0;
          end
        end
        FULL: begin
          // in_ready is low here, so nothing can be accepted.
          if (rel) begin
            state_d = ONE;
            main_d  = skid_q;
            skid_d  = '0;
          end
        end
        default: begin
          // Unreachable encoding: recover to an empty stage.
          state_d = EMPTY;
          main_d  = '0;
          skid_d  = '0;
        end
      endcase
    end
  end

`ifdef PIPE_STAGE_STALL_CNT_EN
  // Saturating count of stalled cycles; only reset clears it, flush does not.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Testbench for pipe_skid_stage (DATA_W = 32). Directed tests for reset,
// streaming, skid, flush and (when PIPE_STAGE_STALL_CNT_EN is defined) the
// stall counter, plus a long randomized run checked by a queue scoreboard.
// The reference model treats the stage as a FIFO of at most two payloads.
module tb_pipe_skid_stage;

  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [3:0]        stall_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Payloads currently held by the stage, oldest first.
  logic [DATA_W-1:0] exp_q[$];

  pipe_skid_stage #(
    .DATA_W(DATA_W)
`ifdef PIPE_STAGE_STALL_CNT_EN
    , .CNT_W(4)
`endif
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef PIPE_STAGE_STALL_CNT_EN
    , .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Input-side scoreboard: sampled just before the rising edge, when the
  // handshake for that edge is settled. Flush and reset empty the model;
  // a payload offered during flush is discarded.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (!reset || flush) begin
        exp_q.delete();
      end else if (in_valid && in_ready) begin
        exp_q.push_back(in_data);
      end
    end
  end

  // Output-side monitor: checks occupancy-derived handshake, bubble data,
  // and pops/compares every payload released downstream. Runs before the
  // input side in the same cycle so a release during flush still counts.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (reset) begin
        check("mon_out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
        check("mon_in_ready",  64'(in_ready),  64'(exp_q.size() < 2));
        if (!out_valid) check("mon_bubble_zero", 64'(out_data), 64'd0);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("mon_unexpected_output", 64'(out_data), 64'hDEAD_BEEF_0000_0000);
          end else begin
            check("mon_order", 64'(out_data), 64'(exp_q.pop_front()));
          end
        end
      end
    end
  end

  // Hard time limit so the run can never hang.
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  // Load 0xA then 0xB with out_ready low, leaving the stage FULL.
  task automatic fill_ab();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hA;
    tick();
    in_data   = 32'hB;
    tick();
    in_valid  = 1'b0;
    in_data   = $urandom;
  endtask

  logic r_before;

  initial begin
    reset     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_data",  64'(out_data),  64'd0);
    check("reset_in_ready",  64'(in_ready),  64'd1);
    tick();
    tick();
    reset = 1'b1;
    tick();

    // Streaming: one payload per cycle, visible one cycle after it is offered.
    out_ready = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      in_valid = 1'b1;
      in_data  = 32'(i);
      tick();
      check("stream_data",     64'(out_data),  64'(i));
      check("stream_valid",    64'(out_valid), 64'd1);
      check("stream_in_ready", 64'(in_ready),  64'd1);
    end
    in_valid = 1'b0;
    tick();
    check("stream_drained", 64'(out_valid), 64'd0);

    // Skid: two payloads held while downstream stalls, then drained in order.
    fill_ab();
    check("skid_full_in_ready", 64'(in_ready), 64'd0);
    check("skid_full_head",     64'(out_data), 64'hA);
    out_ready = 1'b1;
    #1;
    check("skid_first_out", 64'(out_data), 64'hA);
    tick();
    check("skid_second_out",      64'(out_data), 64'hB);
    check("skid_in_ready_reopen", 64'(in_ready), 64'd1);
    tick();
    check("skid_empty_valid", 64'(out_valid), 64'd0);
    check("skid_empty_data",  64'(out_data),  64'd0);

    // Flush while FULL with a payload on offer: everything is discarded.
    fill_ab();
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'hC;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_out_data",  64'(out_data),  64'd0);
    check("flush_in_ready",  64'(in_ready),  64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("flush_no_c", 64'(out_valid), 64'd0);
    end

    // Asynchronous reset mid-stream in FULL: outputs clear without a clock edge.
    fill_ab();
    #1;
    reset = 1'b0;
    #1;
    check("async_rst_out_valid", 64'(out_valid), 64'd0);
    check("async_rst_out_data",  64'(out_data),  64'd0);
    check("async_rst_in_ready",  64'(in_ready),  64'd1);
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("post_rst_empty", 64'(out_valid), 64'd0);

    // Random valid/ready/flush traffic; payloads checked by the scoreboard.
    for (int cyc = 0; cyc < 10000; cyc++) begin
      in_valid  = ($urandom_range(3) != 0);
      in_data   = $urandom;
      out_ready = ($urandom_range(2) != 0);
      flush     = ($urandom_range(63) == 0);
      if (cyc % 500 == 0) begin
        // in_ready must not react to out_ready within the cycle.
        #1;
        r_before  = in_ready;
        out_ready = ~out_ready;
        #1;
        check("in_ready_no_comb_path", 64'(in_ready), 64'(r_before));
        out_ready = ~out_ready;
      end
      tick();
    end
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();
    check("random_all_drained", 64'(exp_q.size()), 64'd0);

`ifdef PIPE_STAGE_STALL_CNT_EN
    // Stall counter: saturating, ignores flush, cleared by reset.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("stall_cnt_reset", 64'(stall_cnt), 64'd0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h55;
    tick();
    in_valid  = 1'b0;
    repeat (5) tick();
    check("stall_cnt_count5", 64'(stall_cnt), 64'd5);
    repeat (15) tick();
    check("stall_cnt_saturate", 64'(stall_cnt), 64'd15);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    check("stall_cnt_after_flush", 64'(stall_cnt), 64'd15);
    reset = 1'b0;
    #1;
    check("stall_cnt_cleared", 64'(stall_cnt), 64'd0);
    tick();
    reset = 1'b1;
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
